// File: rtl/accum_pkg.sv
// Shared types for the B-operand feedback register: debounce states and operand width.
package accum_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_t;

    localparam int OPERAND_W = 2;

    typedef logic [OPERAND_W-1:0] operand_t;

endpackage

// File: rtl/accum_b_register_btn_debounce.sv
// Button synchronizer plus debounce FSM; emits a single-cycle registered press strobe.
//
// state        | meaning
// IDLE         | button released and stable, waiting for a synchronized high
// PRESS_WAIT   | high seen, counting stable-high cycles before accepting the press
// HELD         | press accepted (strobe already fired), waiting for a low
// RELEASE_WAIT | low seen, counting stable-low cycles before accepting the release
module btn_debounce
    import accum_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn_raw,
    output logic o_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_btn_s;

    deb_state_t             r_state;
    deb_state_t             w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   r_press;
    logic                   w_press_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn_raw};
        end
    end

    assign w_btn_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_press <= w_press_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press_nxt = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_btn_s) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!w_btn_s) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_TC) begin
                    // Strobe is registered, so it rises on the edge entering HELD.
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!w_btn_s) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (w_btn_s) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_TC) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_press = r_press;

endmodule

// File: rtl/accum_b_register.sv
// Feedback register holding the 2-bit B operand, loaded/cleared by debounced buttons.
// Define ACCUM_WRAP_FLAG_EN to build the sticky wrap_flag; otherwise it is tied low.
module accum_b_register
    import accum_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     btn_load_raw,
    input  logic     btn_clr_raw,
    input  operand_t sum_in,
    output operand_t b_q,
    output logic     load_pulse,
    output logic     wrap_flag
);

    logic     w_load_press;
    logic     w_clr_press;
    operand_t r_b_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_deb_load (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_btn_raw (btn_load_raw),
        .o_press   (w_load_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_deb_clr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_btn_raw (btn_clr_raw),
        .o_press   (w_clr_press)
    );

    // Clear has priority over a coincident load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_q <= '0;
        end else if (w_clr_press) begin
            r_b_q <= '0;
        end else if (w_load_press) begin
            r_b_q <= sum_in;
        end
    end

`ifdef ACCUM_WRAP_FLAG_EN
    logic r_wrap_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrap_flag <= 1'b0;
        end else if (w_clr_press) begin
            r_wrap_flag <= 1'b0;
        end else if (w_load_press && (sum_in < r_b_q)) begin
            r_wrap_flag <= 1'b1;
        end
    end

    assign wrap_flag = r_wrap_flag;
`else
    assign wrap_flag = 1'b0;
`endif

    assign b_q        = r_b_q;
    assign load_pulse = w_load_press;

endmodule

// File: doc/accum_b_register.md
Name: accum_b_register

Overview:
- Feedback register stage that holds the 2-bit B operand, B1 and B0, for the 2-bit adder/decoder stage.
- The decoder's 2-bit result is fed back here. On a debounced "load" button press, the result is captured and becomes the next B.
- A debounced "clear" button forces B to 0.
- Outputs go straight back to the decoder's B input and to the BCD display path.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronized cycles required to accept a press or release (10 ms at 50 MHz). Must be >= 2.
- SYNC_STAGES, 2: number of flops in each button synchronizer. Must be >= 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- btn_load_raw  input  1  raw, bouncy, asynchronous load button; 1 = pressed.
- btn_clr_raw  input  1  raw, bouncy, asynchronous clear button; 1 = pressed.
- sum_in  input  2  decoder result {A, B} = (A_input + B_q) mod 4.
- b_q  output  2  registered B operand: b_q[1] = B1, b_q[0] = B0.
- load_pulse  output  1  one-cycle strobe marking the cycle in which sum_in is sampled.
- wrap_flag  output  1  sticky wrap indicator. Present only with the optional feature; otherwise tied 0.

Behaviour:
- Reset: clock and reset are fixed as one clock, clk; reset rst_n is asynchronous and active-low.
  - Asserting rst_n low at any time immediately drives b_q = 2'b00, load_pulse = 0, wrap_flag = 0.
  - It also clears both debouncers to IDLE, zeroes their counters and sets all sync flops to 0.
  - Release of reset is sampled on the next rising clk edge.
- Synchronizer: each raw button passes through SYNC_STAGES flops. Only the synchronized value (btn_s) feeds the debounce FSM.
- Debounce FSM, one instance per button. States: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. Counter cnt has width $clog2(DEBOUNCE_CYCLES).
  - IDLE: if btn_s = 1, go to PRESS_WAIT with cnt = 0.
  - PRESS_WAIT:
    - btn_s = 0: go to IDLE, cnt = 0 (bounce rejected).
    - btn_s = 1 and cnt = DEBOUNCE_CYCLES-1: go to HELD and assert press for exactly one cycle, on the transition edge.
    - Otherwise cnt++.
  - HELD: if btn_s = 0, go to RELEASE_WAIT with cnt = 0. Holding the button produces no further pulses.
  - RELEASE_WAIT:
    - btn_s = 1: return to HELD, no pulse.
    - btn_s = 0 and cnt = DEBOUNCE_CYCLES-1: go to IDLE.
    - Otherwise cnt++.
- Press latency: from the first stably-high raw sample to the press pulse is SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- Register update:
  - load_pulse is the load debouncer's press output, registered: high for 1 cycle.
  - In the load_pulse cycle, sum_in is sampled and b_q <= sum_in on the following edge, so b_q changes 1 cycle after load_pulse.
  - A clear press sets b_q <= 2'b00 on the same edge the load would capture.
- Simultaneous clear and load pulse: clear wins; b_q = 0 and the load is discarded. load_pulse is still emitted.
- Wrap-around: arithmetic is mod 4 (3 + 1 loads 0). No saturation.
- sum_in is treated as combinational from the current b_q. Because b_q is stable in the load_pulse cycle, there is no combinational loop through this block.

Optional Feature:
- Macro: ACCUM_WRAP_FLAG_EN.
- Defined:
  - wrap_flag is set, sticky, on the edge where a load captures sum_in < b_q (unsigned). This indicates the 2-bit sum overflowed.
  - It is cleared by a clear press or by reset.
  - If clear and load coincide, the flag clears.
- Undefined: no flag logic is built and wrap_flag is driven constant 0.

Decomposition:
- Package accum_pkg:
  - typedef enum logic [1:0] deb_state_t {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT}
  - localparam OPERAND_W = 2
  - typedef logic [OPERAND_W-1:0] operand_t
- Sub-module btn_debounce, containing the synchronizer, FSM and press pulse. It is instantiated twice, once for load and once for clear.
- The top level holds b_q, load_pulse and the optional wrap_flag.

Test Plan (bench uses DEBOUNCE_CYCLES = 4, SYNC_STAGES = 2):
- Reset and clean load:
  - Reset, then hold rst_n high; sum_in = 2'b10; btn_load_raw high for 20 cycles.
  - Expect exactly one load_pulse, 6 cycles after the rise.
  - Expect b_q = 2'b10 one cycle later and no further pulses while held.
- Bounce rejection:
  - btn_load_raw pattern 1,1,0,1,0,1 then low.
  - Expect no load_pulse and b_q unchanged.
  - Release bounce during HELD (0,1,0 shorter than 4 cycles) must not produce a second pulse.
- Wrap:
  - Set b_q = 3 and sum_in = 0, then press load.
  - Expect b_q = 0, and wrap_flag = 1 with ACCUM_WRAP_FLAG_EN (0 without).
  - Next load with sum_in = 1 from b_q = 0: wrap_flag stays 1.
- Clear priority:
  - Drive both buttons so both press pulses land in the same cycle with sum_in = 2'b11.
  - Expect b_q = 0 and wrap_flag = 0.
- Async reset mid-operation:
  - Assert rst_n low while the load FSM is in PRESS_WAIT and b_q = 2'b01.
  - Expect b_q = 0 immediately, before any clk edge.
  - After release, keeping the button high yields a pulse only after the full 6-cycle latency.
